// File: rtl/axis_input_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axis_input_arbiter_pkg
//
// Shared definitions for the AXI-Stream input arbiter:
//   - default parameter values (port count, tdata/tuser widths)
//   - arbiter FSM state encoding (IDLE / LOCKED)
//   - wrapInc(): modulo increment used to advance the round-robin pointer
// No ports; imported by axis_input_arbiter and axis_input_arbiter_rr_select.
// ---------------------------------------------------------------------------
package axis_input_arbiter_pkg;

  localparam int DEFAULT_NUM_PORTS   = 4;
  localparam int DEFAULT_DATA_WIDTH  = 256;
  localparam int DEFAULT_TUSER_WIDTH = 128;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Port count need not be a power of two, so the pointer wraps explicitly.
  function automatic int wrapInc(input int idx, input int numPorts);
    return (idx + 1 >= numPorts) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_input_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// axis_input_arbiter_rr_select
//
// Purely combinational round-robin picker. Scans the request vector starting
// at the round-robin pointer and wrapping modulo NUM_PORTS, and returns the
// first requesting port.
//
// Ports:
//   req_i      in   NUM_PORTS    request vector (one bit per input port)
//   rr_ptr_i   in   PORT_IDX_W   port with highest priority this cycle
//   grant_o    out  PORT_IDX_W   selected port (0 when nothing requests)
//   any_req_o  out  1            at least one request bit is set
// ---------------------------------------------------------------------------
module axis_input_arbiter_rr_select
  import axis_input_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
  parameter int PORT_IDX_W = 2
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [PORT_IDX_W-1:0] rr_ptr_i,
  output logic [PORT_IDX_W-1:0] grant_o,
  output logic                  any_req_o
);

  // Walk the ports in priority order. The candidate index is one bit wider
  // than the pointer so pointer+offset cannot overflow before the wrap.
  always_comb begin
    logic [PORT_IDX_W:0]   candWide;
    logic [PORT_IDX_W-1:0] cand;
    grant_o   = '0;
    any_req_o = 1'b0;
    candWide  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      candWide = {1'b0, rr_ptr_i} + (PORT_IDX_W+1)'(k);
      if (candWide >= (PORT_IDX_W+1)'(NUM_PORTS)) begin
        candWide = candWide - (PORT_IDX_W+1)'(NUM_PORTS);
      end
      cand = candWide[PORT_IDX_W-1:0];
      if (!any_req_o && req_i[cand]) begin
        grant_o   = cand;
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_input_arbiter.sv
// ---------------------------------------------------------------------------
// axis_input_arbiter
//
// Packet-granular round-robin arbiter sharing one AXI-Stream pipeline between
// NUM_PORTS input streams. In IDLE it grants the first requesting port at or
// after the round-robin pointer; in LOCKED it forwards only that port's beats
// through a single registered output stage until the tlast beat transfers.
// Packets are never interleaved. One IDLE cycle separates packets.
//
// Ports (input port i occupies slice [i*W +: W] of each packed bus):
//   clk, reset     in   clock, asynchronous active-high reset
//   s_axis_tdata   in   NUM_PORTS*C_S_AXIS_DATA_WIDTH
//   s_axis_tkeep   in   NUM_PORTS*C_S_AXIS_DATA_WIDTH/8
//   s_axis_tuser   in   NUM_PORTS*C_S_AXIS_TUSER_WIDTH
//   s_axis_tvalid  in   NUM_PORTS
//   s_axis_tlast   in   NUM_PORTS
//   s_axis_tready  out  NUM_PORTS   only the granted port can be ready
//   m_axis_*       out  registered output beat (data/keep/user/valid/last)
//   m_axis_tready  in   downstream ready
//   active_port    out  PORT_IDX_W  currently granted port
//   busy           out  1           high while LOCKED
// ---------------------------------------------------------------------------
module axis_input_arbiter
  import axis_input_arbiter_pkg::*;
#(
  parameter int NUM_PORTS            = DEFAULT_NUM_PORTS,
  parameter int C_S_AXIS_DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEFAULT_TUSER_WIDTH,
  parameter int PORT_IDX_W           = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,
  output logic [PORT_IDX_W-1:0]                       active_port,
  output logic                                        busy
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  logic [0:0]                      state_q, state_d;
  logic [PORT_IDX_W-1:0]           grant_q, grant_d;
  logic [PORT_IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  data_q, data_d;
  logic [KEEP_W-1:0]               keep_q, keep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_q, user_d;
  logic                            last_q, last_d;
  logic                            valid_q, valid_d;

  logic [PORT_IDX_W-1:0]           selPort;
  logic                            anyReq;
  logic                            outReady;
  logic                            beatAccept;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  grantData;
  logic [KEEP_W-1:0]               grantKeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] grantUser;
  logic                            grantLast;

  axis_input_arbiter_rr_select #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_rr_select (
    .req_i     (s_axis_tvalid),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (selPort),
    .any_req_o (anyReq)
  );

  // The output stage can take a beat when empty or draining this cycle.
  // Ready depends only on registered state and m_axis_tready, never on tvalid.
  assign outReady = !valid_q || m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ST_LOCKED) begin
      s_axis_tready[grant_q] = outReady;
    end
  end

  assign grantData  = s_axis_tdata[int'(grant_q)*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
  assign grantKeep  = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
  assign grantUser  = s_axis_tuser[int'(grant_q)*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
  assign grantLast  = s_axis_tlast[grant_q];
  assign beatAccept = (state_q == ST_LOCKED) && s_axis_tvalid[grant_q] && outReady;

  // Next-state: the output register loads on every accepted beat and empties
  // when downstream takes it without a replacement; the FSM locks on a grant
  // and releases after the tlast beat, advancing the pointer past the winner.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    keep_d   = keep_q;
    user_d   = user_q;
    last_d   = last_q;
    valid_d  = valid_q;

    if (beatAccept) begin
      data_d  = grantData;
      keep_d  = grantKeep;
      user_d  = grantUser;
      last_d  = grantLast;
      valid_d = 1'b1;
    end else if (m_axis_tready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          grant_d = selPort;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (beatAccept && grantLast) begin
          state_d  = ST_IDLE;
          rr_ptr_d = PORT_IDX_W'(wrapInc(int'(grant_q), NUM_PORTS));
        end
      end
    endcase
  end

  // Reset drops any partial packet and clears the output register outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      user_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      user_q   <= user_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tvalid = valid_q;
  assign active_port   = grant_q;
  assign busy          = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axis_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_input_arbiter
//
// Per-port packet sources feed the arbiter; a packet-level reference model
// decides the order packets should leave in (round-robin over ports that
// still hold packets) and queues the expected beats. A monitor pops the queue
// on every output transfer and also checks stall stability and that at most
// one input is ready at a time.
// ---------------------------------------------------------------------------
module tb_axis_input_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP*DW-1:0] sTdata;
  logic [NP*KW-1:0] sTkeep;
  logic [NP*UW-1:0] sTuser;
  logic [NP-1:0]   sTvalid;
  logic [NP-1:0]   sTlast;
  logic [NP-1:0]   sTready;
  logic [DW-1:0]   mTdata;
  logic [KW-1:0]   mTkeep;
  logic [UW-1:0]   mTuser;
  logic            mTvalid;
  logic            mTlast;
  logic            mTready;
  logic [1:0]      activePort;
  logic            busy;

  beat_t         srcQ[NP][$];
  beat_t         modelQ[NP][$];
  beat_t         expQ[$];
  logic [NP-1:0] accepted = '0;
  logic [NP-1:0] midPkt;
  bit            readyRandom = 1'b0;
  bit            gapsOn = 1'b0;
  int            vectors = 0;
  int            fails = 0;
  int            cycle = 0;
  int            rrModel = 0;

  axis_input_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (sTdata),
    .s_axis_tkeep  (sTkeep),
    .s_axis_tuser  (sTuser),
    .s_axis_tvalid (sTvalid),
    .s_axis_tlast  (sTlast),
    .s_axis_tready (sTready),
    .m_axis_tdata  (mTdata),
    .m_axis_tkeep  (mTkeep),
    .m_axis_tuser  (mTuser),
    .m_axis_tvalid (mTvalid),
    .m_axis_tlast  (mTlast),
    .m_axis_tready (mTready),
    .active_port   (activePort),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] randUser();
    logic [UW-1:0] r;
    for (int i = 0; i < UW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit anySrc();
    for (int p = 0; p < NP; p++) if (srcQ[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue packets on the masked ports, then let the packet-level model work
  // out the order they must leave in and push the expected beats.
  task automatic applyStimulus(input logic [NP-1:0] mask, input int maxPkts,
                               input int minLen, input int maxLen);
    beat_t b;
    int    nPkts, len, found, idx;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        nPkts = $urandom_range(1, maxPkts);
        for (int k = 0; k < nPkts; k++) begin
          len = $urandom_range(minLen, maxLen);
          for (int j = 0; j < len; j++) begin
            b.data = randData();
            b.keep = $urandom;
            b.user = randUser();
            b.last = (j == len - 1);
            srcQ[p].push_back(b);
            modelQ[p].push_back(b);
          end
        end
      end
    end
    forever begin
      found = -1;
      for (int k = 0; k < NP; k++) begin
        idx = (rrModel + k) % NP;
        if (found < 0 && modelQ[idx].size() != 0) found = idx;
      end
      if (found < 0) break;
      do begin
        b = modelQ[found].pop_front();
        expQ.push_back(b);
      end while (!b.last);
      rrModel = (found + 1) % NP;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || anySrc()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drainTimeout", DW'(expQ.size() != 0 || anySrc()), DW'(0));
    repeat (3) @(negedge clk);
    checkOutput("busyAfterDrain", DW'(busy), DW'(0));
  endtask

  // Source driver: retires accepted beats, presents the next one, inserts
  // random gaps only inside a packet (never before a first beat, so every
  // port with pending packets is requesting whenever the arbiter is idle),
  // and randomizes downstream ready.
  initial begin
    beat_t b;
    sTdata  = '0;
    sTkeep  = '0;
    sTuser  = '0;
    sTvalid = '0;
    sTlast  = '0;
    midPkt  = '0;
    mTready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (reset) begin
          sTvalid[p] = 1'b0;
          midPkt[p]  = 1'b0;
        end else begin
          if (accepted[p] && srcQ[p].size() != 0) begin
            b = srcQ[p].pop_front();
            midPkt[p]  = !b.last;
            sTvalid[p] = 1'b0;
          end
          if (srcQ[p].size() == 0) begin
            sTvalid[p] = 1'b0;
          end else if (!sTvalid[p]) begin
            if (!(midPkt[p] && gapsOn && $urandom_range(0, 3) == 0)) begin
              b = srcQ[p][0];
              sTdata[p*DW +: DW] = b.data;
              sTkeep[p*KW +: KW] = b.keep;
              sTuser[p*UW +: UW] = b.user;
              sTlast[p]  = b.last;
              sTvalid[p] = 1'b1;
            end
          end
        end
      end
      mTready = readyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  always @(negedge clk) accepted = sTvalid & sTready;

  // Monitor: scoreboard pop on each output transfer, stall stability, and
  // at most one input ready.
  initial begin
    beat_t got, exp, held;
    bit    holdPending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holdPending = 1'b0;
      end else begin
        got = '{data: mTdata, keep: mTkeep, user: mTuser, last: mTlast};
        vectors++;
        if ($countones(sTready) > 1) begin
          fails++;
          $display("[TB] FAIL readyOneHot: got %b, expected at most one bit", sTready);
        end
        if (holdPending) begin
          vectors++;
          if (!mTvalid || got !== held) begin
            fails++;
            $display("[TB] FAIL stallHold: got valid=%b last=%b data=%h, expected valid=1 last=%b data=%h",
                     mTvalid, got.last, got.data, held.last, held.data);
          end
        end
        if (mTvalid && mTready) begin
          vectors++;
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL beat: got unexpected beat data=%h, expected none", got.data);
          end else begin
            exp = expQ.pop_front();
            if (got !== exp) begin
              fails++;
              $display("[TB] FAIL beat: got last=%b keep=%h user=%h data=%h, expected last=%b keep=%h user=%h data=%h",
                       got.last, got.keep, got.user, got.data, exp.last, exp.keep, exp.user, exp.data);
            end
          end
        end
        holdPending = mTvalid && !mTready;
        held = got;
      end
    end
  end

  initial begin
    int start, n;

    #3;
    checkOutput("resetValid", DW'(mTvalid), DW'(0));
    checkOutput("resetReady", DW'(sTready), DW'(0));
    checkOutput("resetBusy", DW'(busy), DW'(0));
    checkOutput("resetData", mTdata, DW'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single 3-beat packet on port 0: first beat two cycles after request,
    // arbiter idle and output empty three cycles after that.
    applyStimulus(4'b0001, 1, 3, 3);
    @(posedge clk);
    #2;
    start = cycle;
    n = 0;
    while (!mTvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("firstBeatLatency", DW'(cycle - start), DW'(2));
    while (cycle < start + 5) @(negedge clk);
    checkOutput("busyAfterPkt", DW'(busy), DW'(0));
    checkOutput("validAfterPkt", DW'(mTvalid), DW'(0));
    waitDrain(200);

    // All ports saturated with 2-beat packets.
    applyStimulus(4'b1111, 2, 2, 2);
    waitDrain(400);

    // Random masks, lengths, gaps and backpressure.
    readyRandom = 1'b1;
    gapsOn      = 1'b1;
    for (int ph = 0; ph < 30; ph++) begin
      applyStimulus(NP'($urandom_range(1, 15)), 3, 1, 5);
      waitDrain(2000);
    end

    // Reset in the middle of a packet.
    readyRandom = 1'b0;
    gapsOn      = 1'b0;
    applyStimulus(4'b0010, 1, 8, 8);
    n = 0;
    while (!mTvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midPktStarted", DW'(mTvalid), DW'(1));
    #2;
    reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      srcQ[p].delete();
      modelQ[p].delete();
    end
    expQ.delete();
    rrModel = 0;
    #1;
    checkOutput("asyncRstValid", DW'(mTvalid), DW'(0));
    checkOutput("asyncRstLast", DW'(mTlast), DW'(0));
    checkOutput("asyncRstData", mTdata, DW'(0));
    checkOutput("asyncRstKeep", DW'(mTkeep), DW'(0));
    checkOutput("asyncRstUser", DW'(mTuser), DW'(0));
    checkOutput("asyncRstReady", DW'(sTready), DW'(0));
    checkOutput("asyncRstBusy", DW'(busy), DW'(0));
    checkOutput("asyncRstPort", DW'(activePort), DW'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Pointer must restart at port 0 after reset.
    applyStimulus(4'b1001, 2, 1, 3);
    waitDrain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/axis_input_arbiter.md
# axis_input_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream packet pipeline (packet FIFO, header parser, stages, deparser) between NUM_PORTS tenant input streams. Sits in front of the packet-processing top level: it selects one requesting input port, locks onto it until that packet's tlast beat has transferred, and forwards beats through a single registered output stage. Packets are never interleaved, so the downstream parser always sees contiguous packets.

## Interface
Parameters:
- NUM_PORTS, 4, number of input streams; legal 2–8.
- C_S_AXIS_DATA_WIDTH, 256, tdata width per port.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per port.
- PORT_IDX_W, 2, index width; must equal clog2(NUM_PORTS).

Ports (port i of each packed input occupies slice [i*W +: W]):
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  sideband (src/dst port, length).
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata / m_axis_tkeep / m_axis_tuser  out  single-port widths  registered output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tready  in  1  downstream ready (driven from !nearly_full of the packet FIFO).
- active_port  out  PORT_IDX_W  currently granted port (valid when busy).
- busy  out  1  high in LOCKED state.

## Operation
- States: IDLE, LOCKED. Registers: state, grant (PORT_IDX_W), rr_ptr (PORT_IDX_W), output register (data, keep, user, last, valid).
- IDLE: if any s_axis_tvalid is high, grant <= first port with tvalid in search order rr_ptr, rr_ptr+1, … wrapping mod NUM_PORTS; state <= LOCKED. No beat accepted in IDLE; all s_axis_tready = 0.
- LOCKED: s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready); all other readies 0. Accepted beat (tvalid & tready on grant) loads the output register, m_axis_tvalid <= 1.
- Accepted beat with tlast: state <= IDLE, rr_ptr <= (grant+1) mod NUM_PORTS.
- Output register: if m_axis_tready and no new beat accepted, m_axis_tvalid <= 0; data fields hold.
- tdata, tkeep, tuser, tlast forwarded unmodified.
- Ungranted ports are stalled, never dropped. Valid deasserted mid-packet on the granted port: arbiter stays LOCKED, waits.
- Single-beat packets (tlast on first beat) fully supported.

## Timing
- Reset: state IDLE, grant 0, rr_ptr 0, m_axis_tvalid 0, m_axis_tlast 0, tdata/tkeep/tuser 0, s_axis_tready 0, busy 0, active_port 0.
- Latency: request in IDLE at cycle N -> grant at N+1, first beat accepted N+1 -> m_axis_tvalid at N+2.
- One idle cycle (IDLE state) between consecutive packets; throughput otherwise 1 beat/cycle with m_axis_tready high.
- s_axis_tready is combinational from m_axis_tready and registered state only; no combinational path from any s_axis_tvalid to s_axis_tready.
- m_axis_tvalid held until m_axis_tready; output fields stable while stalled.
- Reset mid-packet: packet truncated at both sides, output register cleared; no recovery of partial packet.

## Structure
- Shared package: state encoding (IDLE=0, LOCKED=1), default widths 256/128.
- One sub-module natural: rr_select (combinational, request vector + rr_ptr -> grant index + any_req).

## Test plan
- Single port 0, 3-beat packet, m_axis_tready=1 -> beats on m_axis at cycles 2,3,4, tlast on 3rd, busy low at cycle 5, rr_ptr=1.
- Ports 0–3 all requesting continuously, 2-beat packets -> output packet order 0,1,2,3,0; no interleaving; 1 bubble between packets.
- rr_ptr=2, requests on ports 0 and 1 only -> port 0 granted (wrap), then port 1.
- Grant port 1, m_axis_tready low 4 cycles mid-packet -> m_axis fields stable, s_axis_tready[1]=0 during stall, no beat lost or duplicated.
- Granted port drops tvalid 3 cycles mid-packet while port 2 requests -> port 2 not granted until port 1 tlast accepted.
- Assert reset mid-packet -> all outputs zero in same cycle (async), state IDLE, rr_ptr 0 after release.
